// File: rtl/uart_sample_assembler.sv
// Packs byte pairs from the UART receiver into 16-bit samples and buffers them in a FWFT FIFO.
// Drops stale half-samples on an inter-byte timeout; flags overflow and marks complete frames.
module uart_sample_assembler #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned TIMEOUT_CLKS = 25000,
  parameter int unsigned FRAME_LEN    = 187,
  parameter bit          LSB_FIRST    = 1'b1
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Clear,
  input  logic                          i_Rx_DV,
  input  logic [7:0]                    i_Rx_Byte,
  output logic                          o_Sample_Valid,
  output logic [15:0]                   o_Sample,
  input  logic                          i_Sample_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Overflow,
  output logic                          o_Timeout,
  output logic                          o_Frame_Done
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned FW = $clog2(FRAME_LEN + 1);

  typedef enum logic [0:0] {StLow, StHigh} state_e;

  state_e         state_q, state_d;
  logic [7:0]     hold_q, hold_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [FW-1:0]  frame_cnt_q, frame_cnt_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           timeout_q, timeout_d;
  logic           frame_done_q, frame_done_d;
  logic [15:0]    mem_q [FIFO_DEPTH];
  logic [15:0]    sample;
  logic           push_req, push, pop;

  // Byte pairing FSM; i_Clear overrides everything, including a same-cycle DV.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    push_req  = 1'b0;
    sample    = LSB_FIRST ? {i_Rx_Byte, hold_q} : {hold_q, i_Rx_Byte};
    if (i_Clear) begin
      state_d = StLow;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StLow: begin
          if (i_Rx_DV) begin
            hold_d  = i_Rx_Byte;
            timer_d = '0;
            state_d = StHigh;
          end
        end
        StHigh: begin
          if (i_Rx_DV) begin
            push_req = 1'b1;
            state_d  = StLow;
          end else if (timer_q == TW'(TIMEOUT_CLKS - 1)) begin
            timeout_d = 1'b1;
            state_d   = StLow;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = StLow;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop  = (count_q != '0) && i_Sample_Ready;
  assign push = push_req && ((count_q < CW'(FIFO_DEPTH)) || pop);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    if (i_Clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      frame_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (push_req && !push) overflow_d = 1'b1;
      if (push) begin
        if (frame_cnt_q == FW'(FRAME_LEN - 1)) begin
          frame_cnt_d  = '0;
          frame_done_d = 1'b1;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= StLow;
      hold_q       <= '0;
      timer_q      <= '0;
      frame_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      timer_q      <= timer_d;
      frame_cnt_q  <= frame_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= sample;
  end

  // Storage is not reset, so the head is masked while empty.
  assign o_Sample_Valid = (count_q != '0);
  assign o_Sample       = o_Sample_Valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign o_Fifo_Count   = count_q;
  assign o_Overflow     = overflow_q;
  assign o_Timeout      = timeout_q;
  assign o_Frame_Done   = frame_done_q;

endmodule

// File: tb/tb_uart_sample_assembler.sv
// Randomized bench for uart_sample_assembler: a timestamp/queue reference model feeds a
// scoreboard that a negedge monitor drains whenever the DUT hands over a sample.
module tb_uart_sample_assembler;

  localparam int DEPTH = 16;
  localparam int TO    = 25000;
  localparam int FL    = 187;
  localparam bit LSBF  = 1'b1;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        clear   = 1'b0;
  logic        rx_dv   = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        ready   = 1'b0;
  logic        s_valid;
  logic [15:0] s_data;
  logic [4:0]  f_count;
  logic        ovf, tmo, fdone;

  uart_sample_assembler #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CLKS(TO),
    .FRAME_LEN   (FL),
    .LSB_FIRST   (LSBF)
  ) dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_Clear       (clear),
    .i_Rx_DV       (rx_dv),
    .i_Rx_Byte     (rx_byte),
    .o_Sample_Valid(s_valid),
    .o_Sample      (s_data),
    .i_Sample_Ready(ready),
    .o_Fifo_Count  (f_count),
    .o_Overflow    (ovf),
    .o_Timeout     (tmo),
    .o_Frame_Done  (fdone)
  );

  always #5 clk = ~clk;

  int total   = 0;
  int bad     = 0;
  int fd_seen = 0;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: samples the DUT should hold, in order.
  logic [15:0] sb[$];
  int          occ      = 0;
  bit          have_low = 1'b0;
  logic [7:0]  low_b    = 8'h00;
  longint      cyc      = 0;
  longint      low_cyc  = 0;
  bit          e_ovf    = 1'b0;
  bit          e_to     = 1'b0;
  bit          e_fd     = 1'b0;
  int          acc      = 0;
  bit          m_pop;
  logic [15:0] m_s;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      sb.delete();
      occ = 0; have_low = 0; e_ovf = 0; e_to = 0; e_fd = 0; acc = 0;
    end else begin
      cyc++;
      e_to = 0;
      e_fd = 0;
      if (clear) begin
        sb.delete();
        occ = 0; have_low = 0; e_ovf = 0; acc = 0;
      end else begin
        m_pop = (occ > 0) && ready;
        if (rx_dv) begin
          if (!have_low) begin
            have_low = 1;
            low_b    = rx_byte;
            low_cyc  = cyc;
          end else begin
            m_s      = LSBF ? {rx_byte, low_b} : {low_b, rx_byte};
            have_low = 0;
            if (occ < DEPTH || m_pop) begin
              sb.push_back(m_s);
              occ++;
              acc++;
              if (acc % FL == 0) e_fd = 1;
            end else begin
              e_ovf = 1;
            end
          end
        end else if (have_low && cyc == low_cyc + TO) begin
          e_to     = 1;
          have_low = 0;
        end
        if (m_pop) occ--;
      end
    end
  end

  // Monitor: compares flags every cycle and retires scoreboard entries on each handshake.
  initial forever begin
    @(negedge clk);
    chk("valid", s_valid, occ != 0);
    chk("count", f_count, occ);
    chk("overflow", ovf, e_ovf);
    chk("timeout", tmo, e_to);
    chk("frame_done", fdone, e_fd);
    if (fdone) fd_seen++;
    if (s_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sample: DUT presents %0h but no sample is expected", s_data);
      end else begin
        chk("sample", s_data, sb[0]);
        if (ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
    rx_byte = 8'($urandom);
  endtask

  task automatic send_pair(logic [15:0] s, int gap);
    send(LSBF ? s[7:0] : s[15:8]);
    tick(gap);
    send(LSBF ? s[15:8] : s[7:0]);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_valid"}, s_valid, 0);
    chk({tag, "_sample"}, s_data, 0);
    chk({tag, "_count"}, f_count, 0);
    chk({tag, "_overflow"}, ovf, 0);
    chk({tag, "_timeout"}, tmo, 0);
    chk({tag, "_frame_done"}, fdone, 0);
  endtask

  initial begin
    tick(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Single sample: visible one cycle after the second DV, then popped.
    ready = 1'b1;
    send(8'h34);
    send(8'h12);
    chk("latency_valid", s_valid, 1);
    chk("latency_sample", s_data, 16'h1234);
    tick();
    chk("single_drained", f_count, 0);

    // Timeout: stale low byte dropped, following pair assembled normally.
    send(8'hAA);
    tick(TO);
    chk("timeout_pulse", tmo, 1);
    tick();
    chk("timeout_one_cycle", tmo, 0);
    send(8'h01);
    send(8'h00);
    tick(2);

    // Overflow: 17 samples into a stalled 16-deep FIFO.
    ready = 1'b0;
    for (int i = 0; i < 17; i++) send_pair(16'(i), 0);
    chk("ovf_count", f_count, 16);
    chk("ovf_flag", ovf, 1);
    ready = 1'b1;
    tick(18);
    chk("ovf_drained", f_count, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ovf_cleared", ovf, 0);

    // Full FIFO with simultaneous push and pop.
    ready = 1'b0;
    for (int i = 0; i < 16; i++) send_pair(16'h0100 + 16'(i), int'($urandom_range(0, 2)));
    chk("full_count", f_count, 16);
    send(8'hCD);
    ready = 1'b1;
    send(8'hAB);
    ready = 1'b0;
    chk("full_pushpop_count", f_count, 16);
    chk("full_pushpop_ovf", ovf, 0);
    ready = 1'b1;
    tick(18);

    // Frame markers at the 187th and 374th accepted push.
    clear = 1'b1;
    tick();
    clear   = 1'b0;
    fd_seen = 0;
    for (int i = 0; i < 2 * FL; i++) send_pair(16'($urandom), int'($urandom_range(0, 1)));
    tick(3);
    chk("frame_pulses", fd_seen, 2);

    // Second byte on the very cycle the timer expires: DV wins.
    send(8'h5A);
    tick(TO - 1);
    send(8'hA5);
    chk("collision_no_timeout", tmo, 0);
    chk("collision_valid", s_valid, 1);
    chk("collision_sample", s_data, 16'hA55A);
    tick(2);

    // Reset while holding a low byte, with data in the FIFO.
    ready = 1'b0;
    send_pair(16'hBEEF, 0);
    send_pair(16'hCAFE, 1);
    send(8'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick(2);
    rst_n = 1'b1;
    tick();
    ready = 1'b1;
    send(8'h22);
    send(8'h11);
    chk("post_reset_sample", s_data, 16'h1122);
    tick(3);

    // Random traffic with random back-pressure and occasional flushes.
    for (int i = 0; i < 1200; i++) begin
      ready   = ($urandom_range(0, 3) < ((i < 600) ? 3 : 1));
      clear   = ($urandom_range(0, 149) == 0);
      rx_dv   = $urandom_range(0, 1) == 1;
      rx_byte = 8'($urandom);
      tick();
    end
    clear = 1'b0;
    rx_dv = 1'b0;
    ready = 1'b1;
    tick(24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
